// File: rtl/led_seq_ctrl_if.sv
// LED sequencer request/status bundle.
// master: board-side requester (drives mode requests, pause level).
// slave : the sequencer (drives LED bank and status).
interface led_seq_ctrl_if #(
    parameter int unsigned LED_W = 16
);
    logic [1:0]       mode_req;   // 00 OFF, 01 ROT_L, 10 ROT_R, 11 BOUNCE
    logic             mode_vld;   // one-cycle request strobe
    logic             pause;      // level; freezes the prescaler
    logic [LED_W-1:0] ledout;     // registered LED drive
    logic [1:0]       mode;       // current mode
    logic             mode_ack;   // pulse the cycle after a request
    logic             step_tick;  // pulse aligned with each ledout advance

    modport master (
        output mode_req,
        output mode_vld,
        output pause,
        input  ledout,
        input  mode,
        input  mode_ack,
        input  step_tick
    );

    modport slave (
        input  mode_req,
        input  mode_vld,
        input  pause,
        output ledout,
        output mode,
        output mode_ack,
        output step_tick
    );
endinterface

// File: rtl/led_seq_ctrl.sv
// Sequencer for the 16-bit board LED bank: step prescaler plus pattern
// selection (off, rotate-left, rotate-right, bounce).
// Optional feature macro: LED_SEQ_BOUNCE_EN
//   defined   -> BOUNCE mode and its direction register are built.
//   undefined -> a BOUNCE request is acknowledged but lands in OFF.
module led_seq_ctrl #(
    parameter int unsigned TICK_DIV = 5000000,
    parameter int unsigned LED_W    = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    led_seq_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ModeOff    = 2'b00,
        ModeRotL   = 2'b01,
        ModeRotR   = 2'b10,
        ModeBounce = 2'b11
    } mode_e;

    localparam logic [29:0] CntMax = 30'(TICK_DIV - 1);

    // Elaboration-time guards on the configuration.
    if (LED_W != 16) begin : g_bad_width
        $error("led_seq_ctrl: LED_W must be 16");
    end
    if (TICK_DIV < 2 || TICK_DIV > 32'h3fff_ffff) begin : g_bad_div
        $error("led_seq_ctrl: TICK_DIV out of range 2..2^30-1");
    end

    // Seed pattern loaded on a request or on dark-pattern recovery.
    function automatic logic [15:0] seed(input mode_e m);
        logic [15:0] s;
        case (m)
            ModeRotL:   s = 16'h0001;
            ModeRotR:   s = 16'h8000;
            ModeBounce: s = 16'h0001;
            default:    s = 16'h0000;
        endcase
        return s;
    endfunction

    mode_e       mode_q, mode_d;
    mode_e       req_mode;
    logic [15:0] led_q, led_d;
    logic [15:0] step_led;
    logic [29:0] cnt_q, cnt_d;
    logic        ack_q, ack_d;
    logic        tick_q, tick_d;
    logic        terminal;

`ifdef LED_SEQ_BOUNCE_EN
    logic        dir_q, dir_d;     // 0: moving left (towards bit 15), 1: moving right
    logic        step_dir;
`endif

    assign terminal = (cnt_q == CntMax);

    // Map the raw request onto the implemented mode set.
    always_comb begin
        req_mode = mode_e'(bus.mode_req);
`ifndef LED_SEQ_BOUNCE_EN
        if (bus.mode_req == 2'b11) begin
            req_mode = ModeOff;
        end
`endif
    end

    // Pattern value (and bounce direction) after one step of the current mode.
    always_comb begin
        step_led = led_q;
`ifdef LED_SEQ_BOUNCE_EN
        step_dir = dir_q;
`endif
        if (led_q == 16'h0000) begin
            // A lit mode never stays dark: restart from the seed.
            step_led = seed(mode_q);
`ifdef LED_SEQ_BOUNCE_EN
            step_dir = 1'b0;
`endif
        end else begin
            case (mode_q)
                ModeRotL: step_led = {led_q[14:0], led_q[15]};
                ModeRotR: step_led = {led_q[0], led_q[15:1]};
`ifdef LED_SEQ_BOUNCE_EN
                ModeBounce: begin
                    if (!dir_q && led_q[15]) begin
                        step_dir = 1'b1;
                        step_led = led_q >> 1;
                    end else if (dir_q && led_q[0]) begin
                        step_dir = 1'b0;
                        step_led = led_q << 1;
                    end else if (dir_q) begin
                        step_led = led_q >> 1;
                    end else begin
                        step_led = led_q << 1;
                    end
                end
`endif
                default: step_led = led_q;
            endcase
        end
    end

    // Next-state selection: request beats pause beats OFF beats stepping.
    always_comb begin
        mode_d = mode_q;
        led_d  = led_q;
        cnt_d  = cnt_q;
        ack_d  = 1'b0;
        tick_d = 1'b0;
`ifdef LED_SEQ_BOUNCE_EN
        dir_d  = dir_q;
`endif
        if (bus.mode_vld) begin
            // Every strobe is accepted, including a repeat of the current mode.
            mode_d = req_mode;
            led_d  = seed(req_mode);
            cnt_d  = '0;
            ack_d  = 1'b1;
`ifdef LED_SEQ_BOUNCE_EN
            dir_d  = 1'b0;
`endif
        end else if (bus.pause) begin
            // Everything holds; counting resumes from here later.
        end else if (mode_q == ModeOff) begin
            led_d = 16'h0000;
            cnt_d = '0;
        end else if (terminal) begin
            cnt_d  = '0;
            led_d  = step_led;
            tick_d = 1'b1;
`ifdef LED_SEQ_BOUNCE_EN
            dir_d  = step_dir;
`endif
        end else begin
            cnt_d = cnt_q + 30'd1;
        end
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= ModeOff;
            led_q  <= 16'h0000;
            cnt_q  <= '0;
            ack_q  <= 1'b0;
            tick_q <= 1'b0;
`ifdef LED_SEQ_BOUNCE_EN
            dir_q  <= 1'b0;
`endif
        end else begin
            mode_q <= mode_d;
            led_q  <= led_d;
            cnt_q  <= cnt_d;
            ack_q  <= ack_d;
            tick_q <= tick_d;
`ifdef LED_SEQ_BOUNCE_EN
            dir_q  <= dir_d;
`endif
        end
    end

    assign bus.ledout    = led_q;
    assign bus.mode      = mode_q;
    assign bus.mode_ack  = ack_q;
    assign bus.step_tick = tick_q;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Self-checking bench for led_seq_ctrl with TICK_DIV=4.
module tb_led_seq_ctrl;

    localparam int unsigned TickDiv = 4;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    led_seq_ctrl_if #(.LED_W(16)) bus ();

    led_seq_ctrl #(
        .TICK_DIV(TickDiv),
        .LED_W   (16)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        logic        vld;
        logic [1:0]  req;
        logic        pause;
        logic [15:0] led;
        logic [1:0]  mode;
        logic        ack;
        logic        tick;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [15:0] led, input logic [1:0] mode,
                             input logic ack, input logic tick);
        check({tag, ".ledout"}, bus.ledout, led);
        check({tag, ".mode"}, 16'(bus.mode), 16'(mode));
        check({tag, ".mode_ack"}, 16'(bus.mode_ack), 16'(ack));
        check({tag, ".step_tick"}, 16'(bus.step_tick), 16'(tick));
    endtask

    // Drive inputs, take one clock, land #1 after the edge.
    task automatic cyc(input logic vld, input logic [1:0] req, input logic p);
        bus.mode_vld = vld;
        bus.mode_req = req;
        bus.pause    = p;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic vld, input logic [1:0] req, input logic p,
                       input logic [15:0] led, input logic [1:0] mode,
                       input logic ack, input logic tick);
        vec_t v;
        v.vld = vld; v.req = req; v.pause = p;
        v.led = led; v.mode = mode; v.ack = ack; v.tick = tick;
        vecs.push_back(v);
    endtask

    // Run 'steps' pattern steps of 4 cycles each, checking each cycle.
    task automatic sweep(input string tag, input int steps, input int kind);
        logic [15:0] prev;
        logic [15:0] e;
        int          kk;
        prev = bus.ledout;
        for (int k = 1; k <= steps; k++) begin
            case (kind)
                1:       e = 16'h0001 << (k % 16);
                2:       e = 16'h8000 >> (k % 16);
                default: begin
                    kk = k % 30;
                    e  = (kk < 16) ? (16'h0001 << kk) : (16'h0001 << (30 - kk));
                end
            endcase
            for (int j = 0; j < 4; j++) begin
                cyc(1'b0, 2'b00, 1'b0);
                if (j == 3) begin
                    check($sformatf("%s step%0d led", tag, k), bus.ledout, e);
                    check($sformatf("%s step%0d tick", tag, k), 16'(bus.step_tick), 16'd1);
                end else begin
                    check($sformatf("%s step%0d hold", tag, k), bus.ledout, prev);
                    check($sformatf("%s step%0d notick", tag, k), 16'(bus.step_tick), 16'd0);
                end
            end
            prev = e;
        end
    endtask

    initial begin
        bus.mode_vld = 1'b0;
        bus.mode_req = 2'b00;
        bus.pause    = 1'b0;
        rst_n        = 1'b0;

        // Vector table: ROT_L start, pause freeze, request at terminal count,
        // request while paused, request OFF.
        add(1, 2'd1, 0, 16'h0001, 2'd1, 1, 0);
        for (int i = 0; i < 3; i++) add(0, 2'd0, 0, 16'h0001, 2'd1, 0, 0);
        add(0, 2'd0, 0, 16'h0002, 2'd1, 0, 1);
        for (int i = 0; i < 3; i++) add(0, 2'd0, 0, 16'h0002, 2'd1, 0, 0);
        add(0, 2'd0, 0, 16'h0004, 2'd1, 0, 1);
        add(0, 2'd0, 0, 16'h0004, 2'd1, 0, 0);
        for (int i = 0; i < 10; i++) add(0, 2'd0, 1, 16'h0004, 2'd1, 0, 0);
        for (int i = 0; i < 2; i++) add(0, 2'd0, 0, 16'h0004, 2'd1, 0, 0);
        add(0, 2'd0, 0, 16'h0008, 2'd1, 0, 1);
        for (int i = 0; i < 3; i++) add(0, 2'd0, 0, 16'h0008, 2'd1, 0, 0);
        add(1, 2'd1, 0, 16'h0001, 2'd1, 1, 0);
        add(0, 2'd0, 0, 16'h0001, 2'd1, 0, 0);
        add(1, 2'd2, 1, 16'h8000, 2'd2, 1, 0);
        for (int i = 0; i < 3; i++) add(0, 2'd0, 1, 16'h8000, 2'd2, 0, 0);
        for (int i = 0; i < 3; i++) add(0, 2'd0, 0, 16'h8000, 2'd2, 0, 0);
        add(0, 2'd0, 0, 16'h4000, 2'd2, 0, 1);
        add(1, 2'd0, 0, 16'h0000, 2'd0, 1, 0);
        for (int i = 0; i < 4; i++) add(0, 2'd0, 0, 16'h0000, 2'd0, 0, 0);

        // Reset state, then idle in OFF.
        repeat (3) @(posedge clk);
        #1;
        check_all("reset", 16'h0000, 2'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cyc(1'b0, 2'b00, 1'b0);
            check_all($sformatf("idle%0d", i), 16'h0000, 2'd0, 1'b0, 1'b0);
        end

        for (int i = 0; i < vecs.size(); i++) begin
            cyc(vecs[i].vld, vecs[i].req, vecs[i].pause);
            check_all($sformatf("vec%0d", i), vecs[i].led, vecs[i].mode, vecs[i].ack,
                      vecs[i].tick);
        end

        // Full ROT_L cycle including 8000 -> 0001 wrap.
        cyc(1'b1, 2'b01, 1'b0);
        check_all("rotl_req", 16'h0001, 2'd1, 1'b1, 1'b0);
        sweep("rotl", 16, 1);

        // Full ROT_R cycle including 0001 -> 8000 wrap.
        cyc(1'b1, 2'b10, 1'b0);
        check_all("rotr_req", 16'h8000, 2'd2, 1'b1, 1'b0);
        sweep("rotr", 16, 2);

`ifdef LED_SEQ_BOUNCE_EN
        cyc(1'b1, 2'b11, 1'b0);
        check_all("bounce_req", 16'h0001, 2'd3, 1'b1, 1'b0);
        sweep("bounce", 32, 3);
`else
        cyc(1'b1, 2'b11, 1'b0);
        check_all("bounce_off_req", 16'h0000, 2'd0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 2'b00, 1'b0);
            check_all($sformatf("bounce_off%0d", i), 16'h0000, 2'd0, 1'b0, 1'b0);
        end
`endif

        // Mid-pattern asynchronous reset.
        cyc(1'b1, 2'b01, 1'b0);
        for (int i = 0; i < 6; i++) cyc(1'b0, 2'b00, 1'b0);
        check("pre_reset led", bus.ledout, 16'h0002);
        #3;
        rst_n = 1'b0;
        #1;
        check_all("async_reset", 16'h0000, 2'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 2'b00, 1'b0);
            check_all($sformatf("post_reset%0d", i), 16'h0000, 2'd0, 1'b0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/led_seq_ctrl.md
Name: led_seq_ctrl

Overview:
Sequencer for the 16-bit board LED bank. Owns the step prescaler and selects the LED pattern: off, rotate-left, rotate-right or bounce. Switches and buttons request a mode through a one-cycle request strobe, and the block acknowledges each request. Sits between the board input synchronisers and the LED pins.

Parameters:
TICK_DIV, 5000000, clock cycles per pattern step; legal range 2 to 2^30-1
LED_W, 16, LED bank width; fixed at 16 for this revision

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous assert, active-low
mode_req  in  2  requested mode: 00 OFF, 01 ROT_L, 10 ROT_R, 11 BOUNCE
mode_vld  in  1  one-cycle strobe; mode_req is sampled when high
pause  in  1  level; while high the prescaler freezes and no steps occur
ledout  out  16  registered LED drive
mode  out  2  current mode, registered
mode_ack  out  1  one-cycle pulse the cycle after a request is accepted
step_tick  out  1  one-cycle pulse, high in the cycle ledout advances

Behaviour:
- Reset (rst_n low, async): ledout=0, mode=OFF, prescaler cnt=0, dir=left, mode_ack=0, step_tick=0.
- Prescaler cnt is 30 bits wide. It counts 0..TICK_DIV-1. At TICK_DIV-1 it wraps to 0, and ledout advances at that same edge.
  - Inputs at that edge: pause=0, mode!=OFF, no request.
  - step_tick is registered. It is high in the cycle after the advancing edge, aligned with the new ledout value.
- pause=1: cnt holds its value, ledout holds, step_tick=0. Counting resumes from the held count when pause drops.
- Mode OFF: ledout=0, cnt held at 0, step_tick never asserted.
- Request acceptance: every mode_vld=1 cycle is accepted, with no back-pressure. At that edge:
  - mode<=mode_req and cnt<=0.
  - ledout loads the seed: OFF 16'h0000, ROT_L 16'h0001, ROT_R 16'h8000, BOUNCE 16'h0001 with dir<=left.
  - mode_ack=1 for the following cycle.
  - A request equal to the current mode restarts the pattern from its seed.
- A request on the same edge as a terminal count wins: seed is loaded, no advance occurs, step_tick stays 0 next cycle.
- A request while pause=1 is accepted and the seed is loaded. The prescaler stays frozen at 0 until pause drops.
- ROT_L step: ledout<={ledout[14:0],ledout[15]}. 16'h8000 wraps to 16'h0001.
- ROT_R step: ledout<={ledout[0],ledout[15:1]}. 16'h0001 wraps to 16'h8000.
- BOUNCE step:
  - If dir=left and ledout[15]=1: dir<=right, ledout<=ledout>>1.
  - Else if dir=right and ledout[0]=1: dir<=left, ledout<=ledout<<1.
  - Otherwise shift in the direction of dir.
  - Sequence: 0001, 0002 ... 8000, 4000 ... 0001, 0002 ... Period is 30 steps.
- Recovery: if mode!=OFF and ledout==0 at a step edge, reload the mode seed instead of shifting. A light pattern never stalls dark.
- Mid-operation reset: all state returns to reset values immediately. After release the block sits in OFF until the first request.

Optional Feature:
LED_SEQ_BOUNCE_EN
- Defined: BOUNCE mode and the dir register are implemented as described.
- Undefined:
  - Request 11 is accepted and acknowledged, but mode becomes OFF and ledout=0.
  - The dir register is not synthesised.

Test Plan:
All scenarios use TICK_DIV=4.
1. Reset, then 20 idle cycles -> ledout=0, mode=00, step_tick never high, mode_ack never high.
2. mode_vld with mode_req=01 -> mode_ack next cycle, ledout=0001. Then 4 cycles per step: 0002, 0004 ... 8000, 0001. step_tick is high once every 4 cycles, coincident with each change.
3. mode_req=10 -> ledout=8000, then 4000 ... 0001, 8000 (wrap verified).
4. mode_req=11 with LED_SEQ_BOUNCE_EN -> 30-step sequence 0001..8000..0001 with no duplicate at either end. Without the macro: mode=00, ledout=0, mode_ack still pulses.
5. In ROT_L at ledout=0004, hold pause=1 for 10 cycles -> ledout and cnt frozen. After release, the next step occurs at the remaining count, not a full 4 cycles.
6. Request 01 on the terminal-count edge -> ledout=0001, no step_tick. Then assert rst_n low mid-pattern -> ledout=0 and mode=00 asynchronously, before the next clk edge.
